// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared types and constants for the wide GMII frame receiver
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_WAIT_END
    } rx_state_e;

    typedef struct packed {
        logic bad;
        logic runt;
        logic fcs;
        logic over;
    } rx_status_t;

    localparam logic [7:0]  ETH_PRE     = 8'h55;
    localparam logic [7:0]  ETH_SFD     = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Residue as seen on the complemented CRC register after the FCS bytes.
    localparam logic [31:0] CRC_RESIDUE = 32'h2144DF1C;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_8.sv
// rtl/eth_crc32_8.sv - one-byte combinational step of the reflected Ethernet CRC-32
module eth_crc32_8
    import eth_rx_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_gmii_rx_wide.sv
// rtl/eth_gmii_rx_wide.sv - GMII receiver packing bytes onto a DATA_WIDTH stream
// ETH_RX_FCS_STRIP_EN: hold the FCS in a 4-byte window and drop it from the stream.
module eth_gmii_rx_wide
    import eth_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            gmii_rxd,
    input  logic                  gmii_rx_dv,
    input  logic                  gmii_rx_er,
    input  logic                  clk_enable,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [15:0]           rx_frame_len,
    output logic                  start_packet,
    output logic                  error_bad_frame,
    output logic                  error_bad_fcs,
    output logic                  error_runt,
    output logic                  error_oversize
);

    localparam int              CW    = $clog2(KEEP_WIDTH + 1);
    localparam logic [15:0]     MIN_L = 16'(MIN_LEN);
    localparam logic [15:0]     MAX_L = 16'(MAX_LEN);
    localparam logic [CW-1:0]   FULL  = CW'(KEEP_WIDTH);

    logic [7:0]  rxd_q;
    logic        dv_q, er_q;
    rx_state_e   state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [31:0] crc_q, crc_d, crc_step;
    logic        start_d, acc_vld, fin;
    rx_status_t  fin_st, st_q;
    logic        se_q;
    logic        sb_vld_q, sb_vld_d;
    logic [7:0]  sb_data_q, sb_data_d;

    logic [DATA_WIDTH-1:0] pk_data_q, pk_data_d, ins_data;
    logic [CW-1:0]         pk_cnt_q, pk_cnt_d, cnt_ins;

    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [15:0]           len_q, len_d;
    logic                  start_q, bad_q, bad_d, fcs_q, fcs_d, runt_q, runt_d, over_q, over_d;

    eth_crc32_8 u_crc (
        .data    (rxd_q),
        .crc_in  (crc_q),
        .crc_out (crc_step)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        crc_d   = crc_q;
        start_d = 1'b0;
        acc_vld = 1'b0;
        fin     = 1'b0;
        fin_st  = '0;
        case (state_q)
            ST_IDLE: if (dv_q && !er_q && rxd_q == ETH_PRE) state_d = ST_PREAMBLE;
            ST_PREAMBLE: begin
                if (!dv_q) state_d = ST_IDLE;
                else if (er_q) state_d = ST_WAIT_END;
                else if (rxd_q == ETH_SFD) begin
                    state_d = ST_PAYLOAD;
                    start_d = 1'b1;
                    count_d = '0;
                    crc_d   = CRC_INIT;
                end else if (rxd_q != ETH_PRE) state_d = ST_WAIT_END;
            end
            ST_PAYLOAD: begin
                if (!dv_q) begin
                    fin     = 1'b1;
                    state_d = ST_IDLE;
                    if (er_q) fin_st.bad = 1'b1;
                    else if (count_q < MIN_L) begin
                        fin_st.runt = 1'b1;
                        fin_st.bad  = 1'b1;
                    end else if (~crc_q != CRC_RESIDUE) begin
                        fin_st.fcs = 1'b1;
                        fin_st.bad = 1'b1;
                    end
                end else if (er_q) begin
                    fin        = 1'b1;
                    fin_st.bad = 1'b1;
                    state_d    = ST_WAIT_END;
                end else if (count_q == MAX_L) begin
                    fin         = 1'b1;
                    fin_st.over = 1'b1;
                    fin_st.bad  = 1'b1;
                    state_d     = ST_WAIT_END;
                end else begin
                    acc_vld = 1'b1;
                    crc_d   = crc_step;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end
            end
            ST_WAIT_END: if (!dv_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ETH_RX_FCS_STRIP_EN
    logic [3:0][7:0] win_q, win_d;
    logic [2:0]      win_cnt_q, win_cnt_d;

    // A byte only leaves the window once four newer bytes are behind it.
    always_comb begin
        win_d     = win_q;
        win_cnt_d = win_cnt_q;
        sb_vld_d  = 1'b0;
        sb_data_d = sb_data_q;
        if (fin) begin
            win_cnt_d = '0;
        end else if (acc_vld) begin
            if (win_cnt_q == 3'd4) begin
                sb_vld_d  = 1'b1;
                sb_data_d = win_q[0];
                win_d     = {rxd_q, win_q[3], win_q[2], win_q[1]};
            end else begin
                win_d[win_cnt_q[1:0]] = rxd_q;
                win_cnt_d             = win_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q     <= '0;
            win_cnt_q <= '0;
        end else if (clk_enable) begin
            win_q     <= win_d;
            win_cnt_q <= win_cnt_d;
        end
    end
`else
    always_comb begin
        sb_vld_d  = acc_vld;
        sb_data_d = rxd_q;
    end
`endif

    // A full word is held back unless another byte follows, so the end of frame can still tag it.
    always_comb begin
        ins_data = pk_data_q;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (sb_vld_q && pk_cnt_q == CW'(i)) ins_data[i*8 +: 8] = sb_data_q;
        end
        cnt_ins   = pk_cnt_q + CW'(sb_vld_q);
        pk_data_d = pk_data_q;
        pk_cnt_d  = pk_cnt_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        len_d     = len_q;
        bad_d     = 1'b0;
        fcs_d     = 1'b0;
        runt_d    = 1'b0;
        over_d    = 1'b0;
        if (se_q) begin
            tvalid_d  = (pk_cnt_q != '0);
            tlast_d   = 1'b1;
            tuser_d   = st_q.bad;
            tdata_d   = pk_data_q;
            tkeep_d   = (KEEP_WIDTH'(1) << pk_cnt_q) - KEEP_WIDTH'(1);
            len_d     = count_q;
            bad_d     = st_q.bad;
            fcs_d     = st_q.fcs;
            runt_d    = st_q.runt;
            over_d    = st_q.over;
            pk_data_d = '0;
            pk_cnt_d  = '0;
        end else if (sb_vld_q) begin
            pk_data_d = ins_data;
            pk_cnt_d  = cnt_ins;
            if (cnt_ins == FULL && sb_vld_d) begin
                tvalid_d  = 1'b1;
                tdata_d   = ins_data;
                tkeep_d   = '1;
                pk_data_d = '0;
                pk_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_q     <= '0;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            state_q   <= ST_IDLE;
            count_q   <= '0;
            crc_q     <= CRC_INIT;
            se_q      <= 1'b0;
            st_q      <= '0;
            sb_vld_q  <= 1'b0;
            sb_data_q <= '0;
            pk_data_q <= '0;
            pk_cnt_q  <= '0;
        end else if (clk_enable) begin
            rxd_q     <= gmii_rxd;
            dv_q      <= gmii_rx_dv;
            er_q      <= gmii_rx_er;
            state_q   <= state_d;
            count_q   <= count_d;
            crc_q     <= crc_d;
            se_q      <= fin;
            st_q      <= fin_st;
            sb_vld_q  <= sb_vld_d;
            sb_data_q <= sb_data_d;
            pk_data_q <= pk_data_d;
            pk_cnt_q  <= pk_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            len_q    <= '0;
            start_q  <= 1'b0;
            bad_q    <= 1'b0;
            fcs_q    <= 1'b0;
            runt_q   <= 1'b0;
            over_q   <= 1'b0;
        end else if (clk_enable) begin
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            len_q    <= len_d;
            start_q  <= start_d;
            bad_q    <= bad_d;
            fcs_q    <= fcs_d;
            runt_q   <= runt_d;
            over_q   <= over_d;
        end else begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            start_q  <= 1'b0;
            bad_q    <= 1'b0;
            fcs_q    <= 1'b0;
            runt_q   <= 1'b0;
            over_q   <= 1'b0;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tkeep    = tkeep_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tuser    = tuser_q;
    assign rx_frame_len    = len_q;
    assign start_packet    = start_q;
    assign error_bad_frame = bad_q;
    assign error_bad_fcs   = fcs_q;
    assign error_runt      = runt_q;
    assign error_oversize  = over_q;

endmodule

// File: tb/tb_eth_gmii_rx_wide.sv
// tb/tb_eth_gmii_rx_wide.sv - directed frame bench for eth_gmii_rx_wide at 32-bit width
module tb_eth_gmii_rx_wide;

`ifdef ETH_RX_FCS_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif
    localparam int KW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rxd = '0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic        clk_enable = 1'b1;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [15:0] rx_frame_len;
    logic        start_packet, error_bad_frame, error_bad_fcs, error_runt, error_oversize;

    always #5 clk = ~clk;

    eth_gmii_rx_wide #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk             (clk),
        .rst             (rst),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .clk_enable      (clk_enable),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .rx_frame_len    (rx_frame_len),
        .start_packet    (start_packet),
        .error_bad_frame (error_bad_frame),
        .error_bad_fcs   (error_bad_fcs),
        .error_runt      (error_runt),
        .error_oversize  (error_oversize)
    );

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    logic [7:0] rx_bytes[$];
    logic [7:0] frm[$];
    int beats, n_last, n_start, n_bad, n_fcs, n_runt, n_over, keep_err;
    int last_keep, last_user, last_len, last_edge;
    int en_edges = 0;
    int dv0_edge, er_edge;
    bit gap_mode = 1'b0;

    always @(posedge clk) if (clk_enable) en_edges++;

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            beats++;
            for (int k = 0; k < KW; k++)
                if (m_axis_tkeep[k]) rx_bytes.push_back(m_axis_tdata[k*8 +: 8]);
            if (!m_axis_tlast && m_axis_tkeep != 4'hF) keep_err++;
            if (m_axis_tlast) begin
                n_last++;
                last_keep = int'(m_axis_tkeep);
                last_user = int'(m_axis_tuser);
                last_len  = int'(rx_frame_len);
                last_edge = en_edges;
            end
        end
        if (start_packet)    n_start++;
        if (error_bad_frame) n_bad++;
        if (error_bad_fcs)   n_fcs++;
        if (error_runt)      n_runt++;
        if (error_oversize)  n_over++;
    end

    task automatic clear_mon();
        rx_bytes.delete();
        beats = 0; n_last = 0; n_start = 0; n_bad = 0; n_fcs = 0;
        n_runt = 0; n_over = 0; keep_err = 0; last_edge = -100;
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic e);
        bit en;
        gmii_rxd   = d;
        gmii_rx_dv = v;
        gmii_rx_er = e;
        do begin
            en = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            clk_enable = en;
            @(negedge clk);
        end while (!en);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build(input int n, input bit flip);
        logic [31:0] c;
        int nd;
        frm.delete();
        c  = 32'hFFFFFFFF;
        nd = (n >= 4) ? n - 4 : n;
        for (int i = 0; i < nd; i++) begin
            frm.push_back(8'(i * 37 + 11));
            c = crc_upd(c, 8'(i * 37 + 11));
        end
        if (n >= 4) begin
            c = ~c;
            for (int i = 0; i < 4; i++) frm.push_back(c[i*8 +: 8]);
        end
        if (flip) frm[n-1] = frm[n-1] ^ 8'h10;
    endtask

    task automatic send(input int er_at, input int bad_pre_at);
        clear_mon();
        for (int i = 0; i < 7; i++) drive((i == bad_pre_at) ? 8'h54 : 8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            drive(frm[i], 1'b1, (i == er_at));
            if (i == er_at) er_edge = en_edges;
        end
        drive(8'h00, 1'b0, 1'b0);
        dv0_edge = en_edges;
        for (int i = 0; i < 11; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_frame(input string tag, input int exp_n, input int exp_beats,
                                input int exp_keep, input int exp_user, input int exp_len,
                                input int e_runt, input int e_fcs, input int e_over, input int e_bad);
        check_eq({tag, " beats"}, beats, exp_beats);
        check_eq({tag, " tlast_count"}, n_last, (exp_beats > 0) ? 1 : 0);
        if (exp_beats > 0) begin
            check_eq({tag, " last_tkeep"}, last_keep, exp_keep);
            check_eq({tag, " tuser"}, last_user, exp_user);
            check_eq({tag, " rx_frame_len"}, last_len, exp_len);
        end
        check_eq({tag, " start_packet"}, n_start, 1);
        check_eq({tag, " error_runt"}, n_runt, e_runt);
        check_eq({tag, " error_bad_fcs"}, n_fcs, e_fcs);
        check_eq({tag, " error_oversize"}, n_over, e_over);
        check_eq({tag, " error_bad_frame"}, n_bad, e_bad);
        check_eq({tag, " non_last_tkeep"}, keep_err, 0);
        check_eq({tag, " byte_count"}, rx_bytes.size(), exp_n);
        for (int i = 0; i < exp_n && i < rx_bytes.size(); i++)
            check_eq({tag, " byte"}, int'(rx_bytes[i]), int'(frm[i]));
    endtask

    initial begin
        clear_mon();
        repeat (4) @(negedge clk);
        check_eq("reset tvalid", int'(m_axis_tvalid), 0);
        check_eq("reset tdata", int'(m_axis_tdata), 0);
        check_eq("reset tkeep_tlast_tuser", int'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 0);
        check_eq("reset rx_frame_len", int'(rx_frame_len), 0);
        check_eq("reset pulses", int'({start_packet, error_bad_frame, error_bad_fcs,
                                       error_runt, error_oversize}), 0);
        rst = 1'b0;
        repeat (2) drive(8'h00, 1'b0, 1'b0);

        build(64, 1'b0); send(-1, -1);
        expect_frame("good64", STRIP ? 60 : 64, STRIP ? 15 : 16, 15, 0, 64, 0, 0, 0, 0);
        check_eq("good64 tlast_latency", last_edge - dv0_edge, 2);

        build(61, 1'b0); send(-1, -1);
        expect_frame("runt61", STRIP ? 57 : 61, STRIP ? 15 : 16, 1, 1, 61, 1, 0, 0, 1);

        build(100, 1'b1); send(-1, -1);
        expect_frame("badfcs100", STRIP ? 96 : 100, STRIP ? 24 : 25, 15, 1, 100, 0, 1, 0, 1);

        build(80, 1'b0); send(20, -1);
        expect_frame("er20", STRIP ? 16 : 20, STRIP ? 4 : 5, 15, 1, 20, 0, 0, 0, 1);
        check_eq("er20 tlast_latency", last_edge - er_edge, 2);

        build(64, 1'b0); send(-1, -1);
        expect_frame("after_er", STRIP ? 60 : 64, STRIP ? 15 : 16, 15, 0, 64, 0, 0, 0, 0);

        build(1600, 1'b0); send(-1, -1);
        expect_frame("oversize", STRIP ? 1514 : 1518, STRIP ? 379 : 380, 3, 1, 1518, 0, 0, 1, 1);

        build(64, 1'b0); send(-1, 3);
        check_eq("badpre beats", beats, 0);
        check_eq("badpre start_packet", n_start, 0);
        check_eq("badpre error_bad_frame", n_bad, 0);
        check_eq("badpre error_runt", n_runt, 0);

        build(0, 1'b0); send(-1, -1);
        expect_frame("zero", 0, 0, 0, 0, 0, 1, 0, 0, 1);

        build(3, 1'b0); send(-1, -1);
        expect_frame("three", STRIP ? 0 : 3, STRIP ? 0 : 1, 7, 1, 3, 1, 0, 0, 1);

        gap_mode = 1'b1;
        build(64, 1'b0); send(-1, -1);
        expect_frame("gap64", STRIP ? 60 : 64, STRIP ? 15 : 16, 15, 0, 64, 0, 0, 0, 0);
        check_eq("gap64 tlast_latency", last_edge - dv0_edge, 2);
        gap_mode = 1'b0;

        build(64, 1'b0);
        clear_mon();
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) drive(frm[i], 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, 1'b0);
        check_eq("midreset tlast_count", n_last, 0);
        check_eq("midreset error_bad_frame", n_bad, 0);

        send(-1, -1);
        expect_frame("post_reset", STRIP ? 60 : 64, STRIP ? 15 : 16, 15, 0, 64, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
